// File: rtl/bus_trace_monitor_pkg.sv
// Shared types and helpers for the bus trace monitor.
package bus_trace_monitor_pkg;

   // Monitor run states
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   // Width of the cycle stamp, which must hold 0..timeout
   function automatic int stamp_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/bus_trace_monitor_if.sv
// Control, snoop and read-back signals of the bus trace monitor.
interface bus_trace_monitor_if
   import bus_trace_monitor_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 64,
   parameter int TIMEOUT = 300
) ();
   localparam int CW = stamp_w(TIMEOUT);
   localparam int NW = $clog2(DEPTH + 1);

   logic                  start;
   logic [WIDTH-1:0]      bus;
   logic                  rd_en;
   logic [CW+WIDTH-1:0]   rd_data;
   logic                  rd_valid;
   logic [NW-1:0]         count;
   logic                  busy;
   logic                  halted;
   logic                  timeout;
   logic                  overflow;

   modport master (
      output start, bus, rd_en,
      input  rd_data, rd_valid, count, busy, halted, timeout, overflow
   );

   modport slave (
      input  start, bus, rd_en,
      output rd_data, rd_valid, count, busy, halted, timeout, overflow
   );
endinterface

// File: rtl/bus_trace_monitor_trace_fifo.sv
// Single-clock trace FIFO: separate count register, registered output,
// and a bypass so a pop on an empty FIFO can take the same-cycle push.
module trace_fifo #(
   parameter int DEPTH = 64,
   parameter int DW    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr_i,
   input  logic                       push_i,
   input  logic [DW-1:0]              din_i,
   input  logic                       pop_i,
   output logic [DW-1:0]              dout_o,
   output logic                       dout_vld_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH + 1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [NW-1:0] count_q;
   logic [DW-1:0] dout_q;
   logic          vld_q;
   logic          push_ok, pop_ok, empty;

   assign empty   = (count_q == '0);
   assign push_ok = push_i && !clr_i && (count_q != NW'(DEPTH));
   assign pop_ok  = pop_i && !clr_i && (!empty || push_ok);

   // Storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

   // Pointers, occupancy and the registered read port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         vld_q    <= 1'b0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         vld_q    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            dout_q   <= empty ? din_i : mem_q[rd_ptr_q];
         end
         vld_q <= pop_ok;
         if (push_ok && !pop_ok)      count_q <= count_q + NW'(1);
         else if (pop_ok && !push_ok) count_q <= count_q - NW'(1);
      end
   end

   assign dout_o     = dout_q;
   assign dout_vld_o = vld_q;
   assign count_o    = count_q;
endmodule

// File: rtl/bus_trace_monitor.sv
// Run monitor: after start, stamps every bus change into the trace FIFO and
// ends the run on bus stability (halt) or on the cycle budget (timeout).
module bus_trace_monitor
   import bus_trace_monitor_pkg::*;
#(
   parameter int WIDTH         = 16,
   parameter int DEPTH         = 64,
   parameter int STABLE_CYCLES = 8,
   parameter int TIMEOUT       = 300
) (
   input  logic                clk,
   input  logic                rst,
   bus_trace_monitor_if.slave  bif
);
   localparam int CW = stamp_w(TIMEOUT);
   localparam int NW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STABLE_CYCLES);

   state_e            state_q;
   logic [CW-1:0]     cyc_q, cyc_d;
   logic [WIDTH-1:0]  last_q;
   logic [SW-1:0]     stable_q;
   logic              busy_q, halted_q, timeout_q, overflow_q;
   logic              start_ok, capture, changed, push, full, hit_halt, hit_to;
   logic [CW+WIDTH-1:0] entry;
   logic [NW-1:0]     count;

   assign start_ok = bif.start && (state_q == S_IDLE || state_q == S_DONE);
   assign capture  = (state_q == S_CAPTURE);
   assign changed  = (bif.bus != last_q);
   // Stamp counter saturates so a stamp can never wrap
   assign cyc_d    = (cyc_q == CW'(TIMEOUT)) ? cyc_q : cyc_q + CW'(1);
   assign push     = (state_q == S_ARM) || (capture && changed);
   assign entry    = {(state_q == S_ARM) ? '0 : cyc_d, bif.bus};
   assign full     = (count == NW'(DEPTH));
   // stable counts unchanged cycles after the last change, so S-2 here means
   // this no-change cycle completes STABLE_CYCLES cycles of the same value
   assign hit_halt = capture && !changed && (stable_q == SW'(STABLE_CYCLES - 2));
   assign hit_to   = capture && (cyc_d == CW'(TIMEOUT));

   trace_fifo #(.DEPTH(DEPTH), .DW(CW + WIDTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (start_ok),
      .push_i     (push),
      .din_i      (entry),
      .pop_i      (bif.rd_en),
      .dout_o     (bif.rd_data),
      .dout_vld_o (bif.rd_valid),
      .count_o    (count)
   );

   // Run FSM with its counters and sticky status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cyc_q      <= '0;
         last_q     <= '0;
         stable_q   <= '0;
         busy_q     <= 1'b0;
         halted_q   <= 1'b0;
         timeout_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_ok) begin
                  state_q    <= S_ARM;
                  busy_q     <= 1'b1;
                  halted_q   <= 1'b0;
                  timeout_q  <= 1'b0;
                  overflow_q <= 1'b0;
               end
            end
            S_ARM: begin
               cyc_q    <= '0;
               last_q   <= bif.bus;
               stable_q <= '0;
               state_q  <= S_CAPTURE;
            end
            S_CAPTURE: begin
               cyc_q <= cyc_d;
               if (changed) begin
                  last_q   <= bif.bus;
                  stable_q <= '0;
                  if (full) overflow_q <= 1'b1;
               end else begin
                  stable_q <= stable_q + SW'(1);
               end
               if (hit_halt) halted_q  <= 1'b1;
               if (hit_to)   timeout_q <= 1'b1;
               if (hit_halt || hit_to) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bif.count    = count;
   assign bif.busy     = busy_q;
   assign bif.halted   = halted_q;
   assign bif.timeout  = timeout_q;
   assign bif.overflow = overflow_q;
endmodule

// File: tb/tb_bus_trace_monitor.sv
// Randomised and directed bench for bus_trace_monitor with a queue-based
// reference model and a scoreboard drained by an independent monitor.
module tb_bus_trace_monitor;
   localparam int W  = 16;
   localparam int D  = 8;
   localparam int S  = 4;
   localparam int T  = 50;
   localparam int CW = $clog2(T + 1);

   typedef logic [CW+W-1:0] ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bus_trace_monitor_if #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) bif ();

   bus_trace_monitor #(.WIDTH(W), .DEPTH(D), .STABLE_CYCLES(S), .TIMEOUT(T)) dut (
      .clk (clk),
      .rst (rst),
      .bif (bif)
   );

   // Reference model: trace buffer as a queue, run tracked as a cycle index
   // and the length of the current run of equal bus values.
   ent_t       buf_q[$];
   ent_t       sb[$];
   bit         m_busy, m_first, m_halt, m_to, m_ovf, exp_rdv;
   int         m_cyc, m_run;
   logic [W-1:0] m_last;
   int         checks = 0;
   int         passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic void model_reset();
      buf_q.delete();
      sb.delete();
      m_busy = 0; m_first = 0; m_halt = 0; m_to = 0; m_ovf = 0; exp_rdv = 0;
      m_cyc = 0; m_run = 0; m_last = '0;
   endfunction

   function automatic void model_step(input bit st, input logic [W-1:0] b, input bit re);
      bit   wr = 0, used = 0, full, hh, tt;
      ent_t e = '0;
      exp_rdv = 0;
      if (st && !m_busy) begin
         buf_q.delete();
         m_halt = 0; m_to = 0; m_ovf = 0;
         m_busy = 1; m_first = 1;
         return;
      end
      if (m_busy) begin
         if (m_first) begin
            m_cyc = 0; wr = 1; e = {CW'(0), b}; m_last = b; m_run = 1; m_first = 0;
         end else begin
            if (m_cyc < T) m_cyc++;
            if (b !== m_last) begin
               wr = 1; e = {CW'(m_cyc), b}; m_last = b; m_run = 1;
            end else m_run++;
            hh = (m_run == S);
            tt = (m_cyc == T);
            if (hh) m_halt = 1;
            if (tt) m_to = 1;
            if (hh || tt) m_busy = 0;
         end
      end
      full = (buf_q.size() == D);
      if (re && (buf_q.size() > 0 || wr)) begin
         if (buf_q.size() > 0) sb.push_back(buf_q.pop_front());
         else begin
            sb.push_back(e);
            used = 1;
         end
         exp_rdv = 1;
      end
      if (wr) begin
         if (full) m_ovf = 1;
         else if (!used) buf_q.push_back(e);
      end
   endfunction

   task automatic drive(input bit st, input logic [W-1:0] b, input bit re);
      @(negedge clk);
      bif.start = st;
      bif.bus   = b;
      bif.rd_en = re;
      model_step(st, b, re);
   endtask

   task automatic hold(input logic [W-1:0] b);
      int n = 0;
      while (m_busy && n < 200) begin
         drive(0, b, 0);
         n++;
      end
      if (m_busy) chk("hold_bound", 1, 0);
   endtask

   task automatic drain();
      int n = 0;
      while (buf_q.size() > 0 && n < 40) begin
         drive(0, bif.bus, 1);
         n++;
      end
      drive(0, bif.bus, 0);
      chk("drain_empty", buf_q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      bif.start = 0; bif.rd_en = 0;
      model_reset();
      #1;
      chk("rst_busy", bif.busy, 0);
      chk("rst_count", bif.count, 0);
      chk("rst_flags", {bif.halted, bif.timeout, bif.overflow}, 0);
      @(negedge clk);
      rst = 0;
   endtask

   // Monitor: compares each cycle's outputs and pops the scoreboard on rd_valid
   initial begin
      forever begin
         @(posedge clk);
         #1;
         chk("rd_valid", bif.rd_valid, exp_rdv);
         if (bif.rd_valid) begin
            if (sb.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", bif.rd_data, sb.pop_front());
         end else if (exp_rdv && sb.size() > 0) begin
            void'(sb.pop_front());
         end
         chk("count", bif.count, buf_q.size());
         chk("busy", bif.busy, m_busy);
         chk("halted", bif.halted, m_halt);
         chk("timeout", bif.timeout, m_to);
         chk("overflow", bif.overflow, m_ovf);
      end
   end

   initial begin
      logic [W-1:0] steps [6];
      logic [W-1:0] rb;
      steps = '{16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 16'h0003};
      rst = 1;
      bif.start = 0; bif.bus = '0; bif.rd_en = 0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("init_busy", bif.busy, 0);
      chk("init_count", bif.count, 0);
      rst = 0;

      // Reset during capture, then a normal run
      drive(1, 16'h0, 0);
      for (int i = 0; i < 4; i++) drive(0, W'(i + 1), 0);
      do_reset();
      drive(1, 16'h0, 0);
      drive(0, 16'h0007, 0);
      hold(16'h0007);
      drain();

      // Stepped bus ending in halt; expected trace {0,1} {3,2} {5,3}
      drive(1, 16'h0, 0);
      foreach (steps[i]) drive(0, steps[i], 0);
      hold(16'h0003);
      chk("t2_halted", m_halt && !m_to, 1);
      chk("t2_trace", {buf_q[0], buf_q[1], buf_q[2]},
          {CW'(0), 16'h0001, CW'(3), 16'h0002, CW'(5), 16'h0003});
      drain();

      // Toggling bus: overflow and timeout
      drive(1, 16'h0, 0);
      for (int i = 0; i < 200 && m_busy; i++) drive(0, (i % 2) ? 16'h5555 : 16'hAAAA, 0);
      chk("t3_flags", {m_to, m_halt, m_ovf}, 3'b101);
      drain();

      // Start while busy is ignored; start in DONE clears and re-arms
      drive(1, 16'h0, 0);
      drive(0, 16'h0011, 0);
      drive(0, 16'h0012, 0);
      drive(1, 16'h0013, 0);
      hold(16'h0013);
      drive(1, 16'h0, 0);
      drive(0, 16'h0021, 0);
      hold(16'h0021);

      // Single entry in DONE, two back-to-back pops
      drive(0, 16'h0021, 1);
      drive(0, 16'h0021, 1);
      drive(0, 16'h0021, 0);

      // Random runs with random pops and stray starts
      for (int r = 0; r < 25; r++) begin
         rb = W'($urandom_range(0, 3));
         drive(1, rb, $urandom_range(0, 1));
         for (int c = 0; c < 80; c++) begin
            if ($urandom_range(0, 2) == 0) rb = W'($urandom_range(0, 3));
            drive($urandom_range(0, 19) == 0, rb, $urandom_range(0, 9) < 3);
         end
         if ($urandom_range(0, 4) == 0) do_reset();
      end
      drain();
      drive(0, '0, 0);
      chk("sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
